// File: rtl/clock_set_ctrl.sv
// Button sequencer for the 24 h clock/alarm: mode FSM, increment strobes with
// auto-repeat, edit timeout, digit blink, display page and alarm ring control.
//
// state        | meaning
// RUN (0)      | normal display, btn_inc toggles alarm_en
// SET_HOUR (1) | editing clock hours
// SET_MIN (2)  | editing clock minutes (seconds cleared on each step)
// SET_AL_HOUR(3)| editing alarm hours
// SET_AL_MIN(4)| editing alarm minutes
module clock_set_ctrl #(
  parameter int HOLD_MS    = 600,
  parameter int REPEAT_MS  = 150,
  parameter int TIMEOUT_MS = 10000,
  parameter int BLINK_MS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1k,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_match,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       inc_al_hour,
  output logic       inc_al_min,
  output logic [2:0] mode,
  output logic [1:0] disp_sel,
  output logic [3:0] blink_mask,
  output logic       alarm_en,
  output logic       ring
);

  localparam logic [2:0] RUN         = 3'd0;
  localparam logic [2:0] SET_HOUR    = 3'd1;
  localparam logic [2:0] SET_MIN     = 3'd2;
  localparam logic [2:0] SET_AL_HOUR = 3'd3;
  localparam logic [2:0] SET_AL_MIN  = 3'd4;

  localparam int RPT_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);

  localparam logic [RW-1:0] HOLD_TC    = RW'(HOLD_MS);
  localparam logic [RW-1:0] REPEAT_TC  = RW'(REPEAT_MS);
  localparam logic [TW-1:0] TIMEOUT_TC = TW'(TIMEOUT_MS);
  localparam logic [BW-1:0] BLINK_TC   = BW'(BLINK_MS);

  logic [2:0]    mode_q, mode_n;
  logic          prev_mode_q, prev_inc_q;
  logic          armed_q, armed_n;
  logic          rpt_phase_q, rpt_phase_n;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_n, rpt_inc;
  logic [TW-1:0] idle_cnt_q, idle_cnt_n, idle_inc;
  logic [BW-1:0] blink_cnt_q, blink_cnt_n, blink_inc;
  logic          blink_ph_q, blink_ph_n;
  logic          dismissed_q, dismissed_n;
  logic          alarm_en_n, ring_n;
  logic          inc_hour_n, inc_min_n, inc_al_hour_n, inc_al_min_n;
  logic [1:0]    disp_sel_n;
  logic [3:0]    blink_mask_n;

  logic mode_press, inc_press, in_set, mode_adv, rpt_strobe, timeout, stb;

  always_comb begin
    mode_press = prev_mode_q & ~btn_mode;
    // a simultaneous mode press swallows the inc press
    inc_press  = prev_inc_q & ~btn_inc & ~mode_press;
    in_set     = (mode_q >= SET_HOUR) && (mode_q <= SET_AL_MIN);
    mode_adv   = mode_press & ~ring;

    rpt_cnt_n   = rpt_cnt_q;
    rpt_phase_n = rpt_phase_q;
    armed_n     = armed_q;
    rpt_strobe  = 1'b0;
    rpt_inc     = rpt_cnt_q + 1'b1;
    if (inc_press && in_set) begin
      armed_n     = 1'b1;
      rpt_cnt_n   = '0;
      rpt_phase_n = 1'b0;
    end else if (!armed_q || btn_inc || mode_adv || !in_set) begin
      armed_n     = 1'b0;
      rpt_cnt_n   = '0;
      rpt_phase_n = 1'b0;
    end else if (tick_1k) begin
      if (rpt_inc >= (rpt_phase_q ? REPEAT_TC : HOLD_TC)) begin
        rpt_strobe  = 1'b1;
        rpt_cnt_n   = '0;
        rpt_phase_n = 1'b1;
      end else begin
        rpt_cnt_n = rpt_inc;
      end
    end

    timeout    = 1'b0;
    idle_cnt_n = idle_cnt_q;
    idle_inc   = idle_cnt_q + 1'b1;
    if (!in_set || mode_press || inc_press || rpt_strobe) begin
      idle_cnt_n = '0;
    end else if (tick_1k) begin
      if (idle_inc >= TIMEOUT_TC) begin
        timeout    = 1'b1;
        idle_cnt_n = '0;
      end else begin
        idle_cnt_n = idle_inc;
      end
    end

    mode_n = mode_q;
    if (mode_q > SET_AL_MIN || timeout) begin
      mode_n = RUN;
    end else if (mode_adv) begin
      mode_n = (mode_q == SET_AL_MIN) ? RUN : mode_q + 3'd1;
    end

    stb           = (inc_press & in_set) | rpt_strobe;
    inc_hour_n    = stb && (mode_q == SET_HOUR);
    inc_min_n     = stb && (mode_q == SET_MIN);
    inc_al_hour_n = stb && (mode_q == SET_AL_HOUR);
    inc_al_min_n  = stb && (mode_q == SET_AL_MIN);

    alarm_en_n = alarm_en ^ (inc_press && (mode_q == RUN));

    dismissed_n = dismissed_q;
    if (!alarm_match) begin
      dismissed_n = 1'b0;
    end else if (mode_press && ring) begin
      dismissed_n = 1'b1;
    end
    ring_n = alarm_en & alarm_match & ~dismissed_n;

    blink_cnt_n = blink_cnt_q;
    blink_ph_n  = blink_ph_q;
    blink_inc   = blink_cnt_q + 1'b1;
    if (tick_1k) begin
      if (blink_inc >= BLINK_TC) begin
        blink_cnt_n = '0;
        blink_ph_n  = ~blink_ph_q;
      end else begin
        blink_cnt_n = blink_inc;
      end
    end

    blink_mask_n = 4'b0000;
    if (blink_ph_n && btn_inc) begin
      case (mode_n)
        SET_HOUR, SET_AL_HOUR: blink_mask_n = 4'b0011;
        SET_MIN, SET_AL_MIN:   blink_mask_n = 4'b1100;
        default:               blink_mask_n = 4'b0000;
      endcase
    end

    disp_sel_n = (mode_n == SET_AL_HOUR || mode_n == SET_AL_MIN) ? 2'b00 : 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= RUN;
      prev_mode_q <= 1'b1;
      prev_inc_q  <= 1'b1;
      armed_q     <= 1'b0;
      rpt_phase_q <= 1'b0;
      rpt_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      dismissed_q <= 1'b0;
      alarm_en    <= 1'b0;
      ring        <= 1'b0;
      inc_hour    <= 1'b0;
      inc_min     <= 1'b0;
      clr_sec     <= 1'b0;
      inc_al_hour <= 1'b0;
      inc_al_min  <= 1'b0;
      blink_mask  <= 4'b0000;
      disp_sel    <= 2'b11;
    end else begin
      mode_q      <= mode_n;
      prev_mode_q <= btn_mode;
      prev_inc_q  <= btn_inc;
      armed_q     <= armed_n;
      rpt_phase_q <= rpt_phase_n;
      rpt_cnt_q   <= rpt_cnt_n;
      idle_cnt_q  <= idle_cnt_n;
      blink_cnt_q <= blink_cnt_n;
      blink_ph_q  <= blink_ph_n;
      dismissed_q <= dismissed_n;
      alarm_en    <= alarm_en_n;
      ring        <= ring_n;
      inc_hour    <= inc_hour_n;
      inc_min     <= inc_min_n;
      clr_sec     <= inc_min_n;
      inc_al_hour <= inc_al_hour_n;
      inc_al_min  <= inc_al_min_n;
      blink_mask  <= blink_mask_n;
      disp_sel    <= disp_sel_n;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: inputs driven on falling edges, outputs
// checked on the following falling edge against hand-computed values.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1k = 1'b0;
  logic       btn_mode = 1'b1;
  logic       btn_inc = 1'b1;
  logic       alarm_match = 1'b0;
  logic       inc_hour, inc_min, clr_sec, inc_al_hour, inc_al_min;
  logic [2:0] mode;
  logic [1:0] disp_sel;
  logic [3:0] blink_mask;
  logic       alarm_en, ring;

  int n_tests = 0;
  int n_fail  = 0;

  clock_set_ctrl #(
    .HOLD_MS(6), .REPEAT_MS(3), .TIMEOUT_MS(20), .BLINK_MS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1k(tick_1k), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .alarm_match(alarm_match), .inc_hour(inc_hour),
    .inc_min(inc_min), .clr_sec(clr_sec), .inc_al_hour(inc_al_hour),
    .inc_al_min(inc_al_min), .mode(mode), .disp_sel(disp_sel),
    .blink_mask(blink_mask), .alarm_en(alarm_en), .ring(ring)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_tick();
    tick_1k = 1'b1;
    @(negedge clk);
    tick_1k = 1'b0;
  endtask

  // full press/release of btn_mode; leaves outputs of the press cycle unchecked
  task automatic mode_press();
    btn_mode = 1'b0;
    @(negedge clk);
    btn_mode = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_disp"}, disp_sel, 3);
    check({tag, "_mask"}, blink_mask, 0);
    check({tag, "_alarm_en"}, alarm_en, 0);
    check({tag, "_ring"}, ring, 0);
    check({tag, "_strobes"}, {inc_hour, inc_min, clr_sec, inc_al_hour, inc_al_min}, 0);
  endtask

  int exp_mode[5] = '{1, 2, 3, 4, 0};
  int exp_disp[5] = '{3, 3, 0, 0, 3};
  int strobes;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    // mode cycling
    for (int i = 0; i < 5; i++) begin
      btn_mode = 1'b0;
      @(negedge clk);
      check("cycle_mode", mode, exp_mode[i]);
      check("cycle_disp", disp_sel, exp_disp[i]);
      btn_mode = 1'b1;
      @(negedge clk);
    end

    // single press in SET_MIN
    mode_press();
    mode_press();
    check("setmin_mode", mode, 2);
    btn_inc = 1'b0;
    @(negedge clk);
    check("setmin_inc_min", inc_min, 1);
    check("setmin_clr_sec", clr_sec, 1);
    check("setmin_others", {inc_hour, inc_al_hour, inc_al_min}, 0);
    @(negedge clk);
    check("setmin_one_cycle", {inc_min, clr_sec}, 0);
    btn_inc = 1'b1;
    @(negedge clk);

    // auto-repeat in SET_HOUR: modes 2->3->4->0->1
    repeat (3) mode_press();
    mode_press();
    check("hold_mode", mode, 1);
    strobes = 0;
    btn_inc = 1'b0;
    @(negedge clk);
    check("hold_first", inc_hour, 1);
    strobes += int'(inc_hour);
    for (int t = 1; t <= 15; t++) begin
      do_tick();
      check("hold_strobe", inc_hour, (t == 6 || t == 9 || t == 12 || t == 15) ? 1 : 0);
      check("hold_mask", blink_mask, 0);
      strobes += int'(inc_hour);
    end
    check("hold_total", strobes, 5);
    btn_inc = 1'b1;
    @(negedge clk);
    check("release_mask", blink_mask, 4'b0011);
    for (int t = 0; t < 2; t++) begin
      do_tick();
      check("release_no_strobe", inc_hour, 0);
    end

    // timeout in SET_AL_MIN: modes 1->2->3->4
    repeat (3) mode_press();
    check("to_mode_entry", mode, 4);
    repeat (19) do_tick();
    check("to_before", mode, 4);
    do_tick();
    check("to_fired", mode, 0);
    repeat (4) mode_press();
    check("to2_mode_entry", mode, 4);
    repeat (19) do_tick();
    btn_inc = 1'b0;
    do_tick();
    check("to_press_wins_mode", mode, 4);
    check("to_press_wins_strobe", inc_al_min, 1);
    btn_inc = 1'b1;
    @(negedge clk);
    repeat (19) do_tick();
    check("to_cleared", mode, 4);
    do_tick();
    check("to_refired", mode, 0);

    // alarm arm / ring / dismiss
    btn_inc = 1'b0;
    @(negedge clk);
    check("arm_alarm_en", alarm_en, 1);
    btn_inc = 1'b1;
    @(negedge clk);
    alarm_match = 1'b1;
    @(negedge clk);
    check("ring_on", ring, 1);
    btn_mode = 1'b0;
    @(negedge clk);
    check("dismiss_ring", ring, 0);
    check("dismiss_mode", mode, 0);
    btn_mode = 1'b1;
    @(negedge clk);
    check("dismiss_stays", ring, 0);
    alarm_match = 1'b0;
    @(negedge clk);
    alarm_match = 1'b1;
    @(negedge clk);
    check("ring_again", ring, 1);
    btn_inc = 1'b0;
    @(negedge clk);
    check("disarm_alarm_en", alarm_en, 0);
    btn_inc = 1'b1;
    @(negedge clk);
    check("disarm_ring", ring, 0);
    alarm_match = 1'b0;

    // reset during a hold in SET_HOUR
    btn_inc = 1'b0;
    @(negedge clk);
    btn_inc = 1'b1;
    @(negedge clk);
    check("rst_pre_alarm_en", alarm_en, 1);
    mode_press();
    btn_inc = 1'b0;
    @(negedge clk);
    check("rst_pre_strobe", inc_hour, 1);
    repeat (4) do_tick();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midhold_reset");
    btn_inc = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int t = 0; t < 8; t++) begin
      do_tick();
      strobes += int'(inc_hour) + int'(inc_min) + int'(inc_al_hour) + int'(inc_al_min);
    end
    check("post_reset_no_strobe", strobes, 0);
    check("post_reset_mode", mode, 0);
    mode_press();
    btn_inc = 1'b0;
    @(negedge clk);
    check("post_reset_new_press", inc_hour, 1);
    btn_inc = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
